// File: rtl/lpm_mac_pipe.sv
// rtl/lpm_mac_pipe.sv - pipelined multiply-accumulate for dot products
// Operand pairs flow through PIPELINE product registers into a saturating/wrapping accumulator FSM.
module lpm_mac_pipe #(
  parameter int WIDTHA   = 8,
  parameter int WIDTHB   = 8,
  parameter int WIDTHACC = 24,
  parameter int PIPELINE = 2,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic                clock,
  input  logic                aclr,
  input  logic                clken,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [WIDTHA-1:0]   dataa,
  input  logic [WIDTHB-1:0]   datab,
  output logic                out_valid,
  output logic [WIDTHACC-1:0] result,
  output logic                overflow
);

  localparam int WP = WIDTHA + WIDTHB;
  localparam int WS = WIDTHACC + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  logic [WP-1:0]       a_ext;
  logic [WP-1:0]       b_ext;
  logic [WP-1:0]       prod_comb;
  logic [WP-1:0]       pipe_prod [PIPELINE];
  logic [PIPELINE-1:0] pipe_valid;
  logic [PIPELINE-1:0] pipe_first;
  logic [PIPELINE-1:0] pipe_last;

  logic                p_valid;
  logic                p_first;
  logic                p_last;
  logic [WP-1:0]       p_prod;

  state_t              state;
  state_t              state_nx;
  logic [WIDTHACC-1:0] acc;
  logic [WIDTHACC-1:0] acc_nx;
  logic                sticky;
  logic                sticky_nx;
  logic [WS-1:0]       prod_ext;
  logic [WS-1:0]       acc_ext;
  logic [WS-1:0]       sum;
  logic [WIDTHACC-1:0] sat_val;
  logic                do_load;
  logic                ovf_now;

  // Extending both operands to the full product width makes one unsigned
  // multiply correct for signed and unsigned modes alike.
  always_comb begin
    a_ext     = {{WIDTHB{(SIGNED != 0) && dataa[WIDTHA-1]}}, dataa};
    b_ext     = {{WIDTHA{(SIGNED != 0) && datab[WIDTHB-1]}}, datab};
    prod_comb = a_ext * b_ext;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      pipe_valid <= '0;
      pipe_first <= '0;
      pipe_last  <= '0;
    end else if (clken) begin
      pipe_valid[0] <= in_valid;
      pipe_first[0] <= in_valid & in_first;
      pipe_last[0]  <= in_valid & in_last;
      for (int i = 1; i < PIPELINE; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_first[i] <= pipe_first[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clken) begin
      pipe_prod[0] <= prod_comb;
      for (int i = 1; i < PIPELINE; i++) begin
        pipe_prod[i] <= pipe_prod[i-1];
      end
    end
  end

  assign p_valid = pipe_valid[PIPELINE-1];
  assign p_first = pipe_first[PIPELINE-1];
  assign p_last  = pipe_last[PIPELINE-1];
  assign p_prod  = pipe_prod[PIPELINE-1];

  // Any beat outside ACCUM, or a first beat inside it, starts a fresh sum.
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    sticky_nx = sticky;
    prod_ext  = {{(WS-WP){(SIGNED != 0) && p_prod[WP-1]}}, p_prod};
    acc_ext   = {(SIGNED != 0) && acc[WIDTHACC-1], acc};
    do_load   = (state != ACCUM) || p_first;
    sum       = do_load ? prod_ext : (acc_ext + prod_ext);
    if (SIGNED != 0) begin
      ovf_now = sum[WS-1] != sum[WS-2];
      sat_val = sum[WS-1] ? {1'b1, {(WIDTHACC-1){1'b0}}} : {1'b0, {(WIDTHACC-1){1'b1}}};
    end else begin
      ovf_now = sum[WS-1];
      sat_val = '1;
    end
    if (p_valid) begin
      acc_nx    = (ovf_now && (SATURATE != 0)) ? sat_val : sum[WIDTHACC-1:0];
      sticky_nx = do_load ? ovf_now : (sticky | ovf_now);
      state_nx  = p_last ? DONE : ACCUM;
    end else if (state == DONE) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state    <= IDLE;
      acc      <= '0;
      sticky   <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (clken) begin
      state  <= state_nx;
      acc    <= acc_nx;
      sticky <= sticky_nx;
      if (state_nx == DONE) begin
        result   <= acc_nx;
        overflow <= sticky_nx;
      end
    end
  end

  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_lpm_mac_pipe.sv
// tb/tb_lpm_mac_pipe.sv - self-checking bench for lpm_mac_pipe
// Three instances (24-bit saturating, 16-bit saturating, 16-bit wrapping) share one operand stream.
module tb_lpm_mac_pipe;

  logic        clock = 1'b0;
  logic        aclr = 1'b1;
  logic        clken = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  dataa = '0;
  logic [7:0]  datab = '0;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;
  logic [23:0] r0;
  logic [15:0] r1, r2;

  always #5 clock = ~clock;

  lpm_mac_pipe #(.WIDTHA(8), .WIDTHB(8), .WIDTHACC(24), .PIPELINE(2), .SIGNED(1), .SATURATE(1)) dut0 (
    .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .dataa(dataa), .datab(datab), .out_valid(ov0), .result(r0), .overflow(of0));
  lpm_mac_pipe #(.WIDTHA(8), .WIDTHB(8), .WIDTHACC(16), .PIPELINE(2), .SIGNED(1), .SATURATE(1)) dut1 (
    .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .dataa(dataa), .datab(datab), .out_valid(ov1), .result(r1), .overflow(of1));
  lpm_mac_pipe #(.WIDTHA(8), .WIDTHB(8), .WIDTHACC(16), .PIPELINE(2), .SIGNED(1), .SATURATE(0)) dut2 (
    .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .dataa(dataa), .datab(datab), .out_valid(ov2), .result(r2), .overflow(of2));

  typedef struct {
    int     id;
    longint res;
    bit     ovf;
    int     cyc;
  } ev_t;

  ev_t    exp_q[$];
  ev_t    obs_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cnt = 0;
  bit     en_last = 1'b0;
  bit     m_active = 1'b0;
  longint m_acc [3];
  bit     m_sticky [3];
  int     m_w [3] = '{24, 16, 16};
  bit     m_sat [3] = '{1'b1, 1'b1, 1'b0};
  int     p_i;
  bit     o_b;

  function automatic ev_t mk(input int id, input longint res, input bit ovf, input int cyc);
    ev_t e;
    e.id = id; e.res = res; e.ovf = ovf; e.cyc = cyc;
    return e;
  endfunction

  // Exact sum, then either clamp into the signed range or fold it back modulo 2^W.
  function automatic longint step(input int id, input longint acc, input longint p, output bit ovf);
    longint mx, mn, s, m;
    mx  = (longint'(1) << (m_w[id] - 1)) - 1;
    mn  = -mx - 1;
    m   = longint'(1) << m_w[id];
    s   = acc + p;
    ovf = (s > mx) || (s < mn);
    if (ovf) begin
      if (m_sat[id]) s = (s > mx) ? mx : mn;
      else s = (((s - mn) % m) + m) % m + mn;
    end
    return s;
  endfunction

  // Reference model: works per accepted beat; a result is due LAT=PIPELINE+1 enabled edges later.
  always @(posedge clock) begin
    en_last = clken && !aclr;
    if (clken && !aclr) begin
      if (in_valid) begin
        p_i = int'($signed(dataa)) * int'($signed(datab));
        for (int id = 0; id < 3; id++) begin
          if (!m_active || in_first) begin
            m_acc[id] = longint'(p_i);
            m_sticky[id] = 1'b0;
          end else begin
            m_acc[id] = step(id, m_acc[id], longint'(p_i), o_b);
            m_sticky[id] = m_sticky[id] | o_b;
          end
          if (in_last) exp_q.push_back(mk(id, m_acc[id], m_sticky[id], cnt + 3));
        end
        m_active = !in_last;
      end
      cnt++;
    end
  end

  always @(negedge clock) begin
    if (en_last && !aclr) begin
      if (ov0) obs_q.push_back(mk(0, longint'($signed(r0)), of0, cnt));
      if (ov1) obs_q.push_back(mk(1, longint'($signed(r1)), of1, cnt));
      if (ov2) obs_q.push_back(mk(2, longint'($signed(r2)), of2, cnt));
    end
  end

  task automatic beat(input bit v, input bit f, input bit l, input int a, input int b);
    in_valid = v; in_first = f; in_last = l;
    dataa = a[7:0]; datab = b[7:0];
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wait_out();
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (ov0) break;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1; clken = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({ov0, ov1, ov2} !== 3'b000) begin errors++; $display("FAIL reset_valid got=%b need=000", {ov0, ov1, ov2}); end
    checks++;
    if (r0 !== 24'd0 || r1 !== 16'd0 || r2 !== 16'd0) begin
      errors++; $display("FAIL reset_result got=%0h/%0h/%0h need=0", r0, r1, r2);
    end
    checks++;
    if ({of0, of1, of2} !== 3'b000) begin errors++; $display("FAIL reset_overflow got=%b need=000", {of0, of1, of2}); end
    aclr = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    int c0;
    beat(1, 1, 0, 3, 4);
    beat(1, 0, 0, -2, 5);
    c0 = cnt;
    beat(1, 0, 1, 7, -1);
    wait_out();
    checks++;
    if (ov0 !== 1'b1 || cnt !== c0 + 3) begin
      errors++; $display("FAIL basic_latency got valid=%b cyc=%0d need valid=1 cyc=%0d", ov0, cnt, c0 + 3);
    end
    checks++;
    if ($signed(r0) !== -5 || of0 !== 1'b0) begin
      errors++; $display("FAIL basic_result got=%0d ovf=%b need=-5 ovf=0", $signed(r0), of0);
    end
    @(negedge clock);
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b need=0", ov0); end
    idle(2);
  endtask

  task automatic test_single();
    beat(1, 1, 1, -128, -128);
    wait_out();
    checks++;
    if (ov0 !== 1'b1 || $signed(r0) !== 16384 || $signed(r1) !== 16384) begin
      errors++; $display("FAIL single_result got valid=%b r0=%0d r1=%0d need 1/16384/16384", ov0, $signed(r0), r1);
    end
    idle(2);
    checks++;
    if (ov0 !== 1'b0 || $signed(r0) !== 16384) begin
      errors++; $display("FAIL single_hold got valid=%b r0=%0d need valid=0 r0=16384", ov0, $signed(r0));
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    beat(1, 1, 0, 2, 2);
    beat(1, 0, 1, 3, 3);
    beat(1, 1, 1, 1, 1);
    wait_out();
    checks++;
    if (ov0 !== 1'b1 || $signed(r0) !== 13) begin
      errors++; $display("FAIL b2b_first got valid=%b r0=%0d need valid=1 r0=13", ov0, $signed(r0));
    end
    @(negedge clock);
    checks++;
    if (ov0 !== 1'b1 || $signed(r0) !== 1) begin
      errors++; $display("FAIL b2b_second got valid=%b r0=%0d need valid=1 r0=1", ov0, $signed(r0));
    end
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got=%0d need=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.id !== e.id || o.res !== e.res || o.ovf !== e.ovf || o.cyc !== e.cyc) begin
        errors++;
        $display("FAIL b2b_model got dut%0d res=%0d ovf=%b cyc=%0d need dut%0d res=%0d ovf=%b cyc=%0d",
                 o.id, o.res, o.ovf, o.cyc, e.id, e.res, e.ovf, e.cyc);
      end
    end
  endtask

  task automatic test_saturation();
    beat(1, 1, 0, 127, 127);
    for (int i = 0; i < 3; i++) beat(1, 0, 0, 127, 127);
    beat(1, 0, 1, 127, 127);
    wait_out();
    checks++;
    if ($signed(r1) !== 32767 || of1 !== 1'b1) begin
      errors++; $display("FAIL sat_clamp got=%0d ovf=%b need=32767 ovf=1", $signed(r1), of1);
    end
    checks++;
    if ($signed(r2) !== 15109 || of2 !== 1'b1) begin
      errors++; $display("FAIL sat_wrap got=%0d ovf=%b need=15109 ovf=1", $signed(r2), of2);
    end
    checks++;
    if ($signed(r0) !== 80645 || of0 !== 1'b0) begin
      errors++; $display("FAIL sat_wide got=%0d ovf=%b need=80645 ovf=0", $signed(r0), of0);
    end
    beat(1, 1, 1, 1, 2);
    wait_out();
    checks++;
    if (of1 !== 1'b0 || of2 !== 1'b0 || $signed(r2) !== 2) begin
      errors++; $display("FAIL sat_next got ovf=%b%b r2=%0d need ovf=00 r2=2", of1, of2, $signed(r2));
    end
    idle(2);
  endtask

  task automatic test_clken();
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    beat(1, 1, 0, 3, 4);
    clken = 1'b0;
    beat(1, 1, 1, 100, 100);
    beat(1, 0, 1, -50, 7);
    clken = 1'b1;
    beat(1, 0, 0, -2, 5);
    beat(1, 0, 1, 7, -1);
    wait_out();
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (ov0 !== 1'b1 || $signed(r0) !== -5) begin
        errors++; $display("FAIL clken_hold got valid=%b r0=%0d need valid=1 r0=-5", ov0, $signed(r0));
      end
    end
    clken = 1'b1;
    @(negedge clock);
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL clken_release got=%b need=0", ov0); end
    idle(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL clken_count got=%0d need=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.id !== e.id || o.res !== e.res || o.ovf !== e.ovf || o.cyc !== e.cyc) begin
        errors++;
        $display("FAIL clken_model got dut%0d res=%0d ovf=%b cyc=%0d need dut%0d res=%0d ovf=%b cyc=%0d",
                 o.id, o.res, o.ovf, o.cyc, e.id, e.res, e.ovf, e.cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    beat(1, 1, 1, 5, 6);
    idle(4);
    beat(1, 1, 0, 3, 3);
    beat(1, 0, 0, 2, 2);
    in_valid = 1'b0;
    #2 aclr = 1'b1;
    m_active = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || r0 !== 24'd0 || of0 !== 1'b0 || r1 !== 16'd0) begin
      errors++; $display("FAIL reset_mid got valid=%b r0=%0d ovf=%b r1=%0d need all 0", ov0, r0, of0, r1);
    end
    @(negedge clock);
    aclr = 1'b0;
    exp_q.delete(); obs_q.delete();
    idle(1);
    beat(1, 0, 1, 5, 5);
    wait_out();
    checks++;
    if (ov0 !== 1'b1 || $signed(r0) !== 25 || $signed(r1) !== 25 || $signed(r2) !== 25) begin
      errors++; $display("FAIL reset_fresh got valid=%b r=%0d/%0d/%0d need 25", ov0, $signed(r0), $signed(r1), $signed(r2));
    end
    idle(2);
  endtask

  task automatic test_random();
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 400; i++) begin
      clken = ($urandom % 6) != 0;
      beat(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
           int'($urandom % 256), int'($urandom % 256));
    end
    clken = 1'b1;
    beat(1, 0, 1, 1, 1);
    idle(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count got=%0d need=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.id !== e.id || o.res !== e.res || o.ovf !== e.ovf || o.cyc !== e.cyc) begin
        errors++;
        $display("FAIL random_model got dut%0d res=%0d ovf=%b cyc=%0d need dut%0d res=%0d ovf=%b cyc=%0d",
                 o.id, o.res, o.ovf, o.cyc, e.id, e.res, e.ovf, e.cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_back_to_back();
    test_saturation();
    test_clken();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
